// File: rtl/dma_route_pkg.sv
// Shared constants and width helpers for the DMA routing controller.
// Modules build their own sel_t / cnt_t typedefs from these width helpers.
package dma_route_pkg;

   // Address map used by the DMA master: top nibble selects the region.
   localparam logic [31:0] DMA_ADDR_MASK    = 32'hF000_0000;
   localparam logic [31:0] SAURIA_DMA_BASE  = 32'h1000_0000;

   function automatic int sel_width(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   function automatic int cnt_width(input int max_trans);
      return $clog2(max_trans + 1);
   endfunction

endpackage

// File: rtl/dma_route_chan.sv
// One address channel (AW or AR): decode, stall gating, select hold,
// outstanding counter and current-port tracking.
module dma_route_chan
   import dma_route_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_PORTS = 2,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_BASE = '0,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_MASK = '0,
   parameter int DEFAULT_PORT = NUM_PORTS - 1,
   parameter int MAX_TRANS = 8,
   localparam int SEL_WIDTH = sel_width(NUM_PORTS),
   localparam int CNT_WIDTH = cnt_width(MAX_TRANS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  o_ready,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [SEL_WIDTH-1:0]  o_sel,
   input  logic                  i_done,
   output logic                  o_busy,
   output logic                  o_miss_acc,
   output logic                  o_underflow
);

   typedef logic [SEL_WIDTH-1:0] sel_t;
   typedef logic [CNT_WIDTH-1:0] cnt_t;

   localparam cnt_t CNT_MAX = cnt_t'(MAX_TRANS);
   localparam sel_t SEL_DEF = sel_t'(DEFAULT_PORT);

   logic [NUM_PORTS-1:0] match;
   sel_t                 tgt;
   logic                 miss;
   logic                 stall;
   logic                 accept;
   cnt_t                 cnt_reg, cnt_next;
   sel_t                 cur_port_reg;
   sel_t                 sel_reg;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_match
         assign match[gi] = (i_addr & PORT_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                            == PORT_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
      end
   endgenerate

   // Scan downwards so the lowest matching port is the last one written.
   always_comb begin
      tgt  = SEL_DEF;
      miss = 1'b1;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
         if (match[p]) begin
            tgt  = sel_t'(p);
            miss = 1'b0;
         end
      end
   end

   // Registered count only: a done in this cycle frees the slot next cycle.
   assign stall  = ((cnt_reg != '0) && (tgt != cur_port_reg)) || (cnt_reg == CNT_MAX);
   assign o_valid = i_valid & ~stall;
   assign o_ready = i_ready & ~stall;
   assign o_sel   = i_valid ? tgt : sel_reg;
   assign accept  = o_valid & i_ready;

   always_comb begin
      cnt_next = cnt_reg;
      if (accept && !i_done) begin
         cnt_next = cnt_reg + cnt_t'(1);
      end else if (!accept && i_done && (cnt_reg != '0)) begin
         cnt_next = cnt_reg - cnt_t'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_reg      <= '0;
         cur_port_reg <= '0;
         sel_reg      <= '0;
      end else begin
         cnt_reg <= cnt_next;
         sel_reg <= o_sel;
         if (accept) begin
            cur_port_reg <= tgt;
         end
      end
   end

   assign o_busy      = (cnt_reg != '0);
   assign o_miss_acc  = accept & miss;
   assign o_underflow = i_done & ~accept & (cnt_reg == '0);

endmodule

// File: rtl/dma_route_ctrl.sv
// Routes DMA AW/AR requests onto an N-port AXI demux, stalling port
// switches while transactions are in flight; holds sticky error flags.
module dma_route_ctrl
   import dma_route_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_PORTS = 2,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_BASE = '0,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_MASK = '0,
   parameter int DEFAULT_PORT = NUM_PORTS - 1,
   parameter int MAX_TRANS = 8,
   localparam int SEL_WIDTH = sel_width(NUM_PORTS),
   localparam int CNT_WIDTH = cnt_width(MAX_TRANS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_aw_valid,
   input  logic [ADDR_WIDTH-1:0] i_aw_addr,
   output logic                  o_aw_ready,
   output logic                  o_aw_valid,
   input  logic                  i_aw_ready,
   output logic [SEL_WIDTH-1:0]  o_aw_sel,
   input  logic                  i_b_done,
   input  logic                  i_ar_valid,
   input  logic [ADDR_WIDTH-1:0] i_ar_addr,
   output logic                  o_ar_ready,
   output logic                  o_ar_valid,
   input  logic                  i_ar_ready,
   output logic [SEL_WIDTH-1:0]  o_ar_sel,
   input  logic                  i_r_done,
   input  logic                  i_err_clr,
   output logic                  o_aw_busy,
   output logic                  o_ar_busy,
   output logic                  o_decerr,
   output logic                  o_underflow
);

   logic aw_miss_acc, ar_miss_acc;
   logic aw_underflow, ar_underflow;
   logic decerr_reg, underflow_reg;

   dma_route_chan #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .NUM_PORTS    (NUM_PORTS),
      .PORT_BASE    (PORT_BASE),
      .PORT_MASK    (PORT_MASK),
      .DEFAULT_PORT (DEFAULT_PORT),
      .MAX_TRANS    (MAX_TRANS)
   ) u_aw_chan (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_aw_valid),
      .i_addr      (i_aw_addr),
      .o_ready     (o_aw_ready),
      .o_valid     (o_aw_valid),
      .i_ready     (i_aw_ready),
      .o_sel       (o_aw_sel),
      .i_done      (i_b_done),
      .o_busy      (o_aw_busy),
      .o_miss_acc  (aw_miss_acc),
      .o_underflow (aw_underflow)
   );

   dma_route_chan #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .NUM_PORTS    (NUM_PORTS),
      .PORT_BASE    (PORT_BASE),
      .PORT_MASK    (PORT_MASK),
      .DEFAULT_PORT (DEFAULT_PORT),
      .MAX_TRANS    (MAX_TRANS)
   ) u_ar_chan (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_ar_valid),
      .i_addr      (i_ar_addr),
      .o_ready     (o_ar_ready),
      .o_valid     (o_ar_valid),
      .i_ready     (i_ar_ready),
      .o_sel       (o_ar_sel),
      .i_done      (i_r_done),
      .o_busy      (o_ar_busy),
      .o_miss_acc  (ar_miss_acc),
      .o_underflow (ar_underflow)
   );

   // A new error event beats a simultaneous clear so it is never lost.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         decerr_reg    <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (aw_miss_acc || ar_miss_acc) begin
            decerr_reg <= 1'b1;
         end else if (i_err_clr) begin
            decerr_reg <= 1'b0;
         end
         if (aw_underflow || ar_underflow) begin
            underflow_reg <= 1'b1;
         end else if (i_err_clr) begin
            underflow_reg <= 1'b0;
         end
      end
   end

   assign o_decerr    = decerr_reg;
   assign o_underflow = underflow_reg;

endmodule

// File: tb/tb_dma_route_ctrl.sv
// Directed and randomized checks of dma_route_ctrl against an
// outstanding-transaction list model.
module tb_dma_route_ctrl;

   localparam int MAX_TRANS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        aw_valid, aw_ready, b_done;
   logic [31:0] aw_addr;
   logic        ar_valid, ar_ready, r_done;
   logic [31:0] ar_addr;
   logic        err_clr;

   logic o_aw_ready, o_aw_valid, o_ar_ready, o_ar_valid;
   logic [0:0] o_aw_sel, o_ar_sel;
   logic o_aw_busy, o_ar_busy, o_decerr, o_underflow;

   logic d2_aw_ready, d2_aw_valid, d2_ar_ready, d2_ar_valid;
   logic [0:0] d2_aw_sel, d2_ar_sel;
   logic d2_aw_busy, d2_ar_busy, d2_decerr, d2_underflow;

   int tests = 0;
   int failed = 0;

   // Model: list of in-flight target ports per channel, plus last port taken.
   int aw_q[$];
   int ar_q[$];
   int aw_last, ar_last, aw_sel_m, ar_sel_m;
   bit dec_m, uf_m, aw_acc_m, ar_acc_m;

   always #5 clk = ~clk;

   // Port 1 is a catch-all here: no address ever misses.
   dma_route_ctrl #(
      .PORT_BASE ({32'h0000_0000, 32'h1000_0000}),
      .PORT_MASK ({32'h0000_0000, 32'hF000_0000})
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_aw_valid(aw_valid), .i_aw_addr(aw_addr), .o_aw_ready(o_aw_ready),
      .o_aw_valid(o_aw_valid), .i_aw_ready(aw_ready), .o_aw_sel(o_aw_sel),
      .i_b_done(b_done),
      .i_ar_valid(ar_valid), .i_ar_addr(ar_addr), .o_ar_ready(o_ar_ready),
      .o_ar_valid(o_ar_valid), .i_ar_ready(ar_ready), .o_ar_sel(o_ar_sel),
      .i_r_done(r_done), .i_err_clr(err_clr),
      .o_aw_busy(o_aw_busy), .o_ar_busy(o_ar_busy),
      .o_decerr(o_decerr), .o_underflow(o_underflow)
   );

   // Port 1 only covers 0x2xxx_xxxx; other unmapped addresses miss to port 1.
   dma_route_ctrl #(
      .PORT_BASE ({32'h2000_0000, 32'h1000_0000}),
      .PORT_MASK ({32'hF000_0000, 32'hF000_0000})
   ) dut2 (
      .i_clk(clk), .i_rst(rst),
      .i_aw_valid(aw_valid), .i_aw_addr(aw_addr), .o_aw_ready(d2_aw_ready),
      .o_aw_valid(d2_aw_valid), .i_aw_ready(aw_ready), .o_aw_sel(d2_aw_sel),
      .i_b_done(b_done),
      .i_ar_valid(ar_valid), .i_ar_addr(ar_addr), .o_ar_ready(d2_ar_ready),
      .o_ar_valid(d2_ar_valid), .i_ar_ready(ar_ready), .o_ar_sel(d2_ar_sel),
      .i_r_done(r_done), .i_err_clr(err_clr),
      .o_aw_busy(d2_aw_busy), .o_ar_busy(d2_ar_busy),
      .o_decerr(d2_decerr), .o_underflow(d2_underflow)
   );

   function automatic int port_of(input logic [31:0] a);
      return (a[31:28] == 4'h1) ? 0 : 1;
   endfunction

   function automatic bit miss2(input logic [31:0] a);
      return (a[31:28] != 4'h1) && (a[31:28] != 4'h2);
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [3:0]  n;
      logic [27:0] lo;
      n  = 4'($urandom_range(1, 3));
      lo = 28'($urandom) & 28'hFFF_FFF0;
      return {n, lo};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      aw_q.delete();
      ar_q.delete();
      aw_last = 0; ar_last = 0; aw_sel_m = 0; ar_sel_m = 0;
      dec_m = 0; uf_m = 0; aw_acc_m = 0; ar_acc_m = 0;
   endtask

   // Called at a falling edge with inputs already driven; returns at the next one.
   task automatic step();
      int aw_t, ar_t;
      bit aw_st, ar_st, aw_ov, ar_ov, set_dec, set_uf;
      #1;
      aw_t  = port_of(aw_addr);
      ar_t  = port_of(ar_addr);
      aw_st = (aw_q.size() != 0 && aw_t != aw_last) || aw_q.size() == MAX_TRANS;
      ar_st = (ar_q.size() != 0 && ar_t != ar_last) || ar_q.size() == MAX_TRANS;
      aw_ov = aw_valid && !aw_st;
      ar_ov = ar_valid && !ar_st;
      chk("aw_valid", o_aw_valid, aw_ov);
      chk("aw_ready", o_aw_ready, aw_ready && !aw_st);
      chk("aw_sel", o_aw_sel, aw_valid ? aw_t : aw_sel_m);
      chk("ar_valid", o_ar_valid, ar_ov);
      chk("ar_ready", o_ar_ready, ar_ready && !ar_st);
      chk("ar_sel", o_ar_sel, ar_valid ? ar_t : ar_sel_m);
      chk("aw_busy", o_aw_busy, aw_q.size() != 0);
      chk("ar_busy", o_ar_busy, ar_q.size() != 0);
      chk("decerr", o_decerr, 0);
      chk("decerr2", d2_decerr, dec_m);
      chk("underflow", o_underflow, uf_m);
      chk("underflow2", d2_underflow, uf_m);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         aw_sel_m = aw_valid ? aw_t : aw_sel_m;
         ar_sel_m = ar_valid ? ar_t : ar_sel_m;
         aw_acc_m = aw_ov && aw_ready;
         ar_acc_m = ar_ov && ar_ready;
         set_dec  = (aw_acc_m && miss2(aw_addr)) || (ar_acc_m && miss2(ar_addr));
         set_uf   = 0;
         if (aw_acc_m) begin aw_q.push_back(aw_t); aw_last = aw_t; end
         if (ar_acc_m) begin ar_q.push_back(ar_t); ar_last = ar_t; end
         if (b_done) begin
            if (aw_q.size() != 0) void'(aw_q.pop_front()); else set_uf = 1;
         end
         if (r_done) begin
            if (ar_q.size() != 0) void'(ar_q.pop_front()); else set_uf = 1;
         end
         dec_m = set_dec ? 1'b1 : (err_clr ? 1'b0 : dec_m);
         uf_m  = set_uf  ? 1'b1 : (err_clr ? 1'b0 : uf_m);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      aw_valid = 0;
      ar_valid = 0;
      for (int i = 0; i < 20 && (aw_q.size() != 0 || ar_q.size() != 0); i++) begin
         b_done = (aw_q.size() != 0);
         r_done = (ar_q.size() != 0);
         step();
      end
      b_done = 0;
      r_done = 0;
   endtask

   initial begin
      rst = 1; aw_valid = 0; aw_ready = 0; b_done = 0; aw_addr = 0;
      ar_valid = 0; ar_ready = 0; r_done = 0; ar_addr = 0; err_clr = 0;
      model_reset();
      @(negedge clk);
      step();
      aw_valid = 1; aw_addr = 32'h2000_0000;
      step();
      chk("rst_pass_valid", o_aw_valid, 1'b1);
      aw_valid = 0;
      rst = 0;
      step();

      // Port switch on AR waits for the earlier read to complete.
      ar_ready = 1; ar_valid = 1; ar_addr = 32'h1000_0040;
      step();
      ar_addr = 32'h2000_0000;
      step();
      chk("ar_switch_stall", o_ar_valid, 1'b0);
      chk("ar_switch_sel", o_ar_sel, 1'b1);
      r_done = 1;
      step();
      r_done = 0;
      chk("ar_after_done", o_ar_valid, 1'b1);
      step();
      ar_valid = 0;
      #1 chk("ar_sel_hold", o_ar_sel, 1'b1);
      @(negedge clk);
      drain();

      // Outstanding limit on AW.
      aw_ready = 1; aw_valid = 1; aw_addr = 32'h1000_0000;
      repeat (8) step();
      chk("aw_full_ready", o_aw_ready, 1'b0);
      step();
      b_done = 1;
      step();
      b_done = 0;
      chk("aw_full_release", o_aw_ready, 1'b1);
      step();
      aw_valid = 0;
      drain();

      // Accept and done together leave the count unchanged.
      aw_valid = 1;
      repeat (3) step();
      b_done = 1;
      step();
      aw_valid = 0;
      step();
      step();
      chk("aw_cnt3_busy", o_aw_busy, 1'b1);
      step();
      b_done = 0;
      chk("aw_cnt3_empty", o_aw_busy, 1'b0);

      // Unmapped address raises decerr; clear drops it.
      aw_valid = 1; aw_addr = 32'h3000_0000;
      step();
      aw_valid = 0;
      chk("miss_decerr", d2_decerr, 1'b1);
      chk("miss_sel", d2_aw_sel, 1'b1);
      err_clr = 1;
      step();
      err_clr = 0;
      chk("decerr_clr", d2_decerr, 1'b0);
      drain();

      // Underflow, then asynchronous reset mid-burst.
      r_done = 1;
      step();
      r_done = 0;
      chk("uf_set", o_underflow, 1'b1);
      chk("uf_cnt0", o_ar_busy, 1'b0);
      aw_valid = 1; aw_addr = 32'h1000_0000;
      repeat (5) step();
      aw_valid = 0;
      #2 rst = 1;
      #1;
      model_reset();
      chk("async_busy", o_aw_busy, 1'b0);
      chk("async_uf", o_underflow, 1'b0);
      @(negedge clk);
      step();
      rst = 0;
      aw_valid = 1; aw_addr = 32'h2000_0000;
      step();
      aw_valid = 0;
      drain();

      // Randomized traffic; a pending valid is held until accepted.
      for (int i = 0; i < 400; i++) begin
         if (!aw_valid || aw_acc_m) begin
            aw_valid = 1'($urandom_range(0, 1));
            aw_addr  = rand_addr();
         end
         if (!ar_valid || ar_acc_m) begin
            ar_valid = 1'($urandom_range(0, 1));
            ar_addr  = rand_addr();
         end
         aw_ready = ($urandom_range(0, 3) != 0);
         ar_ready = ($urandom_range(0, 3) != 0);
         b_done   = ($urandom_range(0, 3) == 0);
         r_done   = ($urandom_range(0, 3) == 0);
         err_clr  = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
